// File: rtl/ex_alu_ccr.sv
// rtl/ex_alu_ccr.sv - execute-stage 16-bit ALU with condition-code register
//
// Combinational ALU on buffered ID/EX operands plus the CCR {INT,C,N,Z}.
// Owns the flags-pop handshake with the memory stage and, when EX_MUL_EN
// is defined, an iterative shift-add multiplier on op 15. Both hold the
// upstream instruction via ex_busy.
//
// Ports:
//   clk, reset            posedge clock, synchronous active-high reset
//   stall                 freezes CCR, FSM and multiplier state
//   alu_op, alu_src1      operation code, B-operand select
//   rdst_val              operand A
//   rsrc_val/data/shmt/hash_imm   B-operand sources (shmt is also the shift amount)
//   set_*/clr_*           per-flag force to 1 / 0 (clr wins)
//   flags_push_pop, mem_read      CCR push (mem_read=0) / pop (mem_read=1)
//   flags_pop_val/_vld    popped flags from the memory stage
//   alu_result            combinational result
//   flags_out             CCR {INT,C,N,Z}; flags_push_val mirrors it
//   ex_busy               combinational hold request to upstream
//
// Configuration macro: EX_MUL_EN (op 15 = unsigned multiply; otherwise NOP).

module ex_alu_ccr #(
    parameter int W       = 16,
    parameter int MUL_CYC = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic [3:0]   alu_op,
    input  logic [1:0]   alu_src1,
    input  logic [W-1:0] rdst_val,
    input  logic [W-1:0] rsrc_val,
    input  logic [W-1:0] data,
    input  logic [3:0]   shmt,
    input  logic [3:0]   hash_imm,
    input  logic         set_z,
    input  logic         set_n,
    input  logic         set_c,
    input  logic         set_int,
    input  logic         clr_z,
    input  logic         clr_n,
    input  logic         clr_c,
    input  logic         clr_int,
    input  logic         flags_push_pop,
    input  logic         mem_read,
    input  logic [3:0]   flags_pop_val,
    input  logic         flags_pop_vld,
    output logic [W-1:0] alu_result,
    output logic [3:0]   flags_out,
    output logic [3:0]   flags_push_val,
    output logic         ex_busy
);

    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_WAIT_POP = 2'd1
`ifdef EX_MUL_EN
        ,
        S_MUL      = 2'd2,
        S_MUL_DONE = 2'd3
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  ccr, ccr_nxt;
    logic [W-1:0] op_a, op_b;
    logic [W-1:0] res;
    logic        upd_zn, upd_c, c_new;
    logic [W:0]  wide;
    logic        pop_req, mul_issue;
    logic [3:0]  set_v, clr_v;

    assign op_a    = rdst_val;
    assign pop_req = flags_push_pop & mem_read;
    assign set_v   = {set_int, set_c, set_n, set_z};
    assign clr_v   = {clr_int, clr_c, clr_n, clr_z};

`ifdef EX_MUL_EN
    localparam int CW = $clog2(MUL_CYC + 1);
    logic [2*W-1:0] mcand, acc;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    assign mul_issue = (state == S_RUN) && (alu_op == 4'd15) && !pop_req;
`else
    assign mul_issue = 1'b0;
`endif

    always_comb begin
        case (alu_src1)
            2'd0:    op_b = rsrc_val;
            2'd1:    op_b = data;
            2'd2:    op_b = {{(W-4){1'b0}}, shmt};
            default: op_b = {{(W-4){1'b0}}, hash_imm};
        endcase
    end

    always_comb begin
        res    = op_a;
        upd_zn = 1'b0;
        upd_c  = 1'b0;
        c_new  = 1'b0;
        wide   = '0;
        case (alu_op)
            4'd1:  res = op_b;
            4'd2:  begin wide = {1'b0, op_a} + {1'b0, op_b}; res = wide[W-1:0]; c_new = wide[W];
                         upd_zn = 1'b1; upd_c = 1'b1; end
            4'd3:  begin res = op_a - op_b; c_new = (op_a < op_b); upd_zn = 1'b1; upd_c = 1'b1; end
            4'd4:  begin res = op_a & op_b; upd_zn = 1'b1; end
            4'd5:  begin res = op_a | op_b; upd_zn = 1'b1; end
            4'd6:  begin res = ~op_a; upd_zn = 1'b1; end
            4'd7:  begin wide = {1'b0, op_a} + {1'b0, ONE}; res = wide[W-1:0]; c_new = wide[W];
                         upd_zn = 1'b1; upd_c = 1'b1; end
            4'd8:  begin res = op_a - ONE; c_new = (op_a == '0); upd_zn = 1'b1; upd_c = 1'b1; end
            // Carry out of a shift is the last bit shifted off; a zero shift leaves C alone.
            4'd9:  begin wide = {1'b0, op_a} << shmt; res = wide[W-1:0]; c_new = wide[W];
                         upd_zn = 1'b1; upd_c = (shmt != 4'd0); end
            4'd10: begin wide = {op_a, 1'b0} >> shmt; res = wide[W:1]; c_new = wide[0];
                         upd_zn = 1'b1; upd_c = (shmt != 4'd0); end
            4'd11: begin res = '0 - op_a; c_new = (op_a != '0); upd_zn = 1'b1; upd_c = 1'b1; end
            4'd12: res = op_b;
            4'd13: res = op_a + op_b;
            4'd14: begin res = op_a ^ op_b; upd_zn = 1'b1; end
`ifdef EX_MUL_EN
            // Only meaningful in MUL_DONE; earlier cycles are busy so no flag commit happens.
            4'd15: begin res = acc[W-1:0]; c_new = |acc[2*W-1:W]; upd_zn = 1'b1; upd_c = 1'b1; end
`endif
            default: res = op_a;
        endcase
    end

    assign alu_result = res;

    always_comb begin
        ex_busy = 1'b0;
        case (state)
            S_RUN:      ex_busy = (pop_req & ~flags_pop_vld) | mul_issue;
            S_WAIT_POP: ex_busy = pop_req & ~flags_pop_vld;
`ifdef EX_MUL_EN
            S_MUL:      ex_busy = 1'b1;
`endif
            default:    ex_busy = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (pop_req && !flags_pop_vld)
                    state_nxt = S_WAIT_POP;
                else if (mul_issue)
`ifdef EX_MUL_EN
                    state_nxt = S_MUL;
`else
                    state_nxt = S_RUN;
`endif
            end
            S_WAIT_POP: if (flags_pop_vld) state_nxt = S_RUN;
`ifdef EX_MUL_EN
            S_MUL:      if (cnt == CW'(MUL_CYC - 1)) state_nxt = S_MUL_DONE;
            S_MUL_DONE: state_nxt = S_RUN;
`endif
            default:    state_nxt = S_RUN;
        endcase
    end

    // A pop instruction never takes ALU or set/clr updates; an instruction only
    // touches the CCR in the cycle it retires (ex_busy low).
    always_comb begin
        ccr_nxt = ccr;
        if (state == S_WAIT_POP || pop_req) begin
            if (flags_pop_vld)
                ccr_nxt = flags_pop_val;
        end else if (!ex_busy) begin
            if (upd_zn) begin
                ccr_nxt[0] = (res == '0);
                ccr_nxt[1] = res[W-1];
            end
            if (upd_c)
                ccr_nxt[2] = c_new;
            ccr_nxt = (ccr_nxt | set_v) & ~clr_v;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RUN;
            ccr   <= 4'b0;
        end else if (!stall) begin
            state <= state_nxt;
            ccr   <= ccr_nxt;
        end
    end

`ifdef EX_MUL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (!stall) begin
            if (mul_issue) begin
                mcand  <= {{W{1'b0}}, op_a};
                mplier <= op_b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == S_MUL) begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
        end
    end
`endif

    assign flags_out      = ccr;
    assign flags_push_val = ccr;

endmodule
